bnn_layer_sequencer: RTL and testbench
======================================

// Module: bnn_layer_sequencer
// PURPOSE
//  Top-level controller for the binary CNN datapath. Accepts a 28x28 binary image as
//  byte beats, then sequences the 3-bit state bus through LOAD -> LAYER_1 -> LAYER_2
//  -> LAYER_3. Waits on each layer's done flag, clears the layers between images and
//  flags hung layers via a per-layer watchdog.
// PARAMETERS
//  BEAT_W   8      pixel bits per input beat; N_PIX / BEAT_W must be an integer
//  N_PIX    784    image bits (28x28)
//  TIMEOUT  8191   max cycles spent in any LAYER_x state before error
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      request a new inference; sampled only in IDLE
//  in_valid     in   1      pixel beat valid
//  in_data      in   BEAT_W pixel beat; bit i -> pixels[beat*BEAT_W + i]
//  in_ready     out  1      beat accepted when in_valid & in_ready
//  pixels       out  N_PIX  assembled image, held stable from LAYER_1 until next load
//  state        out  3      layer state bus: 000 IDLE, 001 LOAD, 010 L1, 011 L2, 100 L3
//  layer_rst_n  out  1      synchronous reset to layers: rst_n & ~clr_pulse
//  l1_done      in   1      layer-1 complete (sticky until layer reset)
//  l2_done      in   1      layer-2 complete (sticky)
//  l3_done      in   1      layer-3 complete (sticky)
//  busy         out  1      high in every FSM state except IDLE
//  result_valid out  1      1-cycle pulse: layer-3 output valid
//  error        out  1      sticky watchdog flag; cleared when start is accepted
// BEHAVIOUR
//  Reset values: FSM=IDLE, beat counter=0, watchdog=0, pixels=0, in_ready=0, busy=0,
//   result_valid=0, error=0, clr_pulse=0.
//  FSM states:   IDLE, LOAD, L1, L2, L3, FIN.
//   FIN drives state=000.
//   - IDLE: start=1 -> LOAD next cycle. clr_pulse=1 for that same cycle, so
//     layer_rst_n=0 on the first LOAD cycle. error and the beat counter are cleared.
//   - LOAD: in_ready=1. Each accepted beat writes pixels[k*BEAT_W +: BEAT_W] and
//     increments k. On the beat with k = N_PIX/BEAT_W-1 -> L1 next cycle.
//     in_valid=0 stalls indefinitely with no timeout. Earlier pixels are held.
//   - L1/L2/L3: in_ready=0. Watchdog cleared on state entry and incremented every
//     cycle. lN_done=1 -> next layer state (L3 -> FIN).
//     Else if watchdog = TIMEOUT -> IDLE with error=1.
//   - FIN: result_valid=1 for exactly this cycle; then IDLE unconditionally.
//  Latency: start -> state=001 after 1 cycle. Last beat -> state=010 after 1 cycle.
//   lN_done -> state advances after 1 cycle.
//  Done flags from a layer other than the current one are ignored.
//   Example: l2_done high while in L1 has no effect.
//  A done flag sampled in the same cycle the watchdog hits TIMEOUT: done wins (advance,
//   no error).
//  start outside IDLE is ignored (no restart, no queuing).
//  start and in_valid together in IDLE: start is taken; the beat is not accepted
//   because in_ready=0.
//  Beat counter width is clog2(N_PIX/BEAT_W). It never wraps; it is cleared on start.
//  pixels is not cleared on start. Every bit is overwritten by the complete load.
//  rst_n low in any state: return to IDLE next edge with all outputs at reset values.
//   layer_rst_n follows rst_n combinationally.
// TESTING
//  1. Reset, start, 98 back-to-back beats 0x00..0x61, then l1/l2/l3_done each 5
//     cycles after entry -> state sequence 000,001,010,011,100,000. pixels[7:0]=0x00,
//     pixels[783:776]=0x61. result_valid high 1 cycle after l3_done.
//  2. LOAD with in_valid toggling every other cycle -> 98 beats accepted, no timeout,
//     state=010 one cycle after the 98th beat.
//  3. L2 with l2_done never asserted (TIMEOUT=8191) -> state=000 and error=1 exactly
//     8192 cycles after L2 entry. A following start clears error.
//  4. start pulsed during L1; l2_done pulsed during L1 -> both ignored, state stays 010
//     until l1_done.
//  5. rst_n=0 mid-LOAD at beat 40 -> state=000, in_ready=0, pixels=0, layer_rst_n=0.
//     A new start requires the full 98 beats.
//  6. Second start after FIN -> layer_rst_n low for the first LOAD cycle only.

Source files
------------

// File: rtl/bnn_layer_sequencer.sv
//------------------------------------------------------------------------------
// bnn_layer_sequencer
//   Loads a binary image as byte beats, then steps the layer state bus through
//   L1 -> L2 -> L3 with per-layer done handshake and a watchdog.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bnn_layer_sequencer #(
  parameter int BEAT_W  = 8,
  parameter int N_PIX   = 784,
  parameter int TIMEOUT = 8191
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_data,
  output logic              in_ready,
  output logic [N_PIX-1:0]  pixels,
  output logic [2:0]        state,
  output logic              layer_rst_n,
  input  logic              l1_done,
  input  logic              l2_done,
  input  logic              l3_done,
  output logic              busy,
  output logic              result_valid,
  output logic              error
);

  localparam int N_BEATS = N_PIX / BEAT_W;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_L1   = 3'd2;
  localparam logic [2:0] S_L2   = 3'd3;
  localparam logic [2:0] S_L3   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [N_PIX-1:0] pixels_q, pixels_d;
  logic             error_q, error_d;
  logic             clr_q, clr_d;

  logic             start_acc;
  logic             beat_acc;
  logic             in_layer;
  logic             cur_done;
  logic             wd_expired;

  assign start_acc  = (fsm_q == S_IDLE) && start;
  assign beat_acc   = (fsm_q == S_LOAD) && in_valid;
  assign in_layer   = (fsm_q == S_L1) || (fsm_q == S_L2) || (fsm_q == S_L3);
  assign wd_expired = (wd_q == WD_LIMIT);

  // Only the done flag of the layer currently running is honoured.
  always_comb begin
    cur_done = 1'b0;
    case (fsm_q)
      S_L1:    cur_done = l1_done;
      S_L2:    cur_done = l2_done;
      S_L3:    cur_done = l3_done;
      default: cur_done = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  // Next-state logic; done takes priority over an expiring watchdog
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: if (start) fsm_d = S_LOAD;
      S_LOAD: if (in_valid && (beat_q == LAST_BEAT)) fsm_d = S_L1;
      S_L1: begin
        if (cur_done)        fsm_d = S_L2;
        else if (wd_expired) fsm_d = S_IDLE;
      end
      S_L2: begin
        if (cur_done)        fsm_d = S_L3;
        else if (wd_expired) fsm_d = S_IDLE;
      end
      S_L3: begin
        if (cur_done)        fsm_d = S_FIN;
        else if (wd_expired) fsm_d = S_IDLE;
      end
      S_FIN:   fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Outputs; FIN is reported on the bus as IDLE
  always_comb begin
    in_ready     = (fsm_q == S_LOAD);
    busy         = (fsm_q != S_IDLE);
    result_valid = (fsm_q == S_FIN);
    state        = (fsm_q == S_FIN) ? S_IDLE : fsm_q;
  end

  always_comb begin
    beat_d   = beat_q;
    wd_d     = '0;
    pixels_d = pixels_q;
    error_d  = error_q;
    clr_d    = start_acc;

    if (start_acc) begin
      beat_d  = '0;
      error_d = 1'b0;
    end else if (beat_acc) begin
      pixels_d[int'(beat_q) * BEAT_W +: BEAT_W] = in_data;
      if (beat_q != LAST_BEAT) beat_d = beat_q + 1'b1;
    end

    // Watchdog restarts on every layer entry and counts while the layer runs
    if (in_layer && (fsm_d == fsm_q)) wd_d = wd_q + 1'b1;

    if (in_layer && !cur_done && wd_expired) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q   <= '0;
      wd_q     <= '0;
      pixels_q <= '0;
      error_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      wd_q     <= wd_d;
      pixels_q <= pixels_d;
      error_q  <= error_d;
      clr_q    <= clr_d;
    end
  end

  assign pixels      = pixels_q;
  assign error       = error_q;
  assign layer_rst_n = rst_n & ~clr_q;

endmodule

`default_nettype wire

// File: tb/tb_bnn_layer_sequencer.sv
//------------------------------------------------------------------------------
// tb_bnn_layer_sequencer
//   Directed bench for bnn_layer_sequencer with a state-transition scoreboard.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bnn_layer_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [783:0] pixels;
  logic [2:0]   state;
  logic         layer_rst_n;
  logic         l1_done;
  logic         l2_done;
  logic         l3_done;
  logic         busy;
  logic         result_valid;
  logic         error;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [2:0]   st_q[$];
  logic [2:0]   prev_st;
  logic [2:0]   exp_st;
  bit           sb_en = 1'b0;
  logic [783:0] exp_pix = '0;

  bnn_layer_sequencer #(
    .BEAT_W  (8),
    .N_PIX   (784),
    .TIMEOUT (8191)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .pixels       (pixels),
    .state        (state),
    .layer_rst_n  (layer_rst_n),
    .l1_done      (l1_done),
    .l2_done      (l2_done),
    .l3_done      (l3_done),
    .busy         (busy),
    .result_valid (result_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: observed=no end expected=end of sequence");
    $fatal(1, "simulation time limit exceeded");
  end

  // Every change of the state bus must match the next expected value queued
  always @(negedge clk) begin
    if (sb_en && (state !== prev_st)) begin
      n_cmp++;
      assert (st_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed=%0h expected=no transition", state);
      end
      if (st_q.size() != 0) begin
        exp_st = st_q.pop_front();
        assert (state === exp_st) else begin
          n_err++;
          $error("FAIL sb_state: observed=%0h expected=%0h", state, exp_st);
        end
      end
    end
    prev_st <= state;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag);
    n_cmp++;
    assert (pixels === exp_pix) else begin
      n_err++;
      $error("FAIL %s: observed low=%0h high=%0h expected low=%0h high=%0h",
             tag, pixels[63:0], pixels[783:720], exp_pix[63:0], exp_pix[783:720]);
    end
  endtask

  // start together with a junk beat: the beat must not be taken
  task automatic do_start();
    l1_done  = 1'b0;
    l2_done  = 1'b0;
    l3_done  = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    st_q.push_back(3'b001);
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_state", 32'(state), 32'h1);
    chk("start_layer_rst_n", 32'(layer_rst_n), 32'h0);
    chk("start_error_clr", 32'(error), 32'h0);
    chk("start_in_ready", 32'(in_ready), 32'h1);
  endtask

  task automatic load(input int nb, input bit gap, input logic [7:0] base);
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(k);
      exp_pix[k*8 +: 8] = in_data;
      if (k == 97) st_q.push_back(3'b010);
      step();
      in_valid = 1'b0;
      if (k == 0) chk("load_layer_rst_n", 32'(layer_rst_n), 32'h1);
      if (k < 97) begin
        chk("load_state", 32'(state), 32'h1);
        if (gap) begin
          step();
          chk("stall_state", 32'(state), 32'h1);
        end
      end else begin
        chk("l1_entry_state", 32'(state), 32'h2);
        chk("l1_in_ready", 32'(in_ready), 32'h0);
      end
    end
  endtask

  task automatic run_layers(input int first, input int delay);
    for (int n = first; n <= 3; n++) begin
      for (int d = 0; d < delay; d++) begin
        step();
        chk("layer_hold", 32'(state), 32'(n + 1));
      end
      case (n)
        1:       l1_done = 1'b1;
        2:       l2_done = 1'b1;
        default: l3_done = 1'b1;
      endcase
      st_q.push_back((n < 3) ? 3'(n + 2) : 3'b000);
      step();
      chk("layer_advance", 32'(state), (n < 3) ? 32'(n + 2) : 32'h0);
    end
    chk("fin_result_valid", 32'(result_valid), 32'h1);
    chk("fin_busy", 32'(busy), 32'h1);
    step();
    chk("idle_result_valid", 32'(result_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_error", 32'(error), 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    l1_done  = 1'b0;
    l2_done  = 1'b0;
    l3_done  = 1'b0;
    repeat (3) step();

    chk("rst_state", 32'(state), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_result_valid", 32'(result_valid), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_layer_rst_n", 32'(layer_rst_n), 32'h0);
    chk_pix("rst_pixels");
    rst_n = 1'b1;
    step();
    chk("rel_layer_rst_n", 32'(layer_rst_n), 32'h1);
    sb_en = 1'b1;

    // Back-to-back load of 0x00..0x61, layers done 5 cycles after entry
    do_start();
    load(98, 1'b0, 8'h00);
    chk("pix_first_byte", 32'(pixels[7:0]), 32'h00);
    chk("pix_last_byte", 32'(pixels[783:776]), 32'h61);
    chk_pix("pix_full_1");
    run_layers(1, 4);

    // Stalling load, then stray start and l2_done while in L1
    do_start();
    load(98, 1'b1, 8'h80);
    chk_pix("pix_full_2");
    start   = 1'b1;
    l2_done = 1'b1;
    step();
    start   = 1'b0;
    l2_done = 1'b0;
    chk("l1_ignore_stray", 32'(state), 32'h2);
    step();
    chk("l1_still", 32'(state), 32'h2);
    run_layers(1, 0);

    // L2 hangs: watchdog expiry 8192 cycles after entry
    do_start();
    load(98, 1'b0, 8'h33);
    l1_done = 1'b1;
    st_q.push_back(3'b011);
    step();
    chk("l2_entry", 32'(state), 32'h3);
    st_q.push_back(3'b000);
    repeat (8191) step();
    chk("l2_before_timeout", 32'(state), 32'h3);
    chk("l2_no_error_yet", 32'(error), 32'h0);
    step();
    chk("timeout_state", 32'(state), 32'h0);
    chk("timeout_error", 32'(error), 32'h1);
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_no_result", 32'(result_valid), 32'h0);
    step();
    chk("error_sticky", 32'(error), 32'h1);

    // l1_done on the very cycle the watchdog expires: done wins
    do_start();
    load(98, 1'b0, 8'h5A);
    repeat (8191) step();
    chk("l1_at_limit", 32'(state), 32'h2);
    l1_done = 1'b1;
    st_q.push_back(3'b011);
    step();
    chk("done_beats_timeout", 32'(state), 32'h3);
    chk("done_no_error", 32'(error), 32'h0);
    run_layers(2, 1);

    // Reset in the middle of a load
    do_start();
    load(40, 1'b0, 8'h10);
    rst_n    = 1'b0;
    exp_pix  = '0;
    st_q.push_back(3'b000);
    step();
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    chk("midrst_layer_rst_n", 32'(layer_rst_n), 32'h0);
    chk_pix("midrst_pixels");
    rst_n = 1'b1;
    step();
    do_start();
    load(98, 1'b0, 8'h20);
    chk_pix("pix_full_after_rst");
    run_layers(1, 2);

    repeat (2) step();
    chk("sb_drain", 32'(st_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
